// File: rtl/signal_analysis_pkg.sv
// Shared constants and sample type for the NMR receive path.
// DATA_W_DEF / LOG2_DECIM_DEF are the default generator/analysis widths.
package signal_analysis_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int LOG2_DECIM_DEF = 3;

  // one mixer/integrator lane per LO phase
  localparam int NUM_LANES = 2;
  localparam int LANE_I    = 0;
  localparam int LANE_Q    = 1;

  typedef logic signed [DATA_W_DEF-1:0] sample_t;

endpackage

// File: rtl/signal_analysis_if.sv
// Sample/LO inputs and decimated I/Q outputs of the receive demodulator.
interface signal_analysis_if
  import signal_analysis_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

  logic signed [DATA_W-1:0] signal_in;
  logic signed [DATA_W-1:0] dds_i;
  logic signed [DATA_W-1:0] dds_q;
  logic                     rx;
  logic signed [DATA_W-1:0] data_out_i;
  logic signed [DATA_W-1:0] data_out_q;
  logic                     data_valid;

  modport master (
      output signal_in, dds_i, dds_q, rx,
      input  data_out_i, data_out_q, data_valid
  );

  modport slave (
      input  signal_in, dds_i, dds_q, rx,
      output data_out_i, data_out_q, data_valid
  );

endinterface

// File: rtl/signal_analysis_iq_mixer_integrator.sv
// One demodulator lane: Q1.15 mix with saturation, then accumulate-and-dump.
// Window timing (rx_d2, win_last) comes from the shared counter in the top.
module iq_mixer_integrator
  import signal_analysis_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LOG2_DECIM = LOG2_DECIM_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] sig_s1,
    input  logic signed [DATA_W-1:0] lo_s1,
    input  logic                     rx_d2,
    input  logic                     win_last,
    output logic signed [DATA_W-1:0] data_out
);

    localparam int ACC_W = DATA_W + LOG2_DECIM;
    localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    logic signed [2*DATA_W-1:0] prod;
    logic                       prod_unused;
    logic signed [DATA_W-1:0]   mixed_d, mixed_q;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    acc_d, acc_q;
    logic signed [DATA_W-1:0]   data_out_d, data_out_q;

    assign prod_unused = ^{prod[2*DATA_W-1], prod[DATA_W-2:0]};

    always_comb begin
        prod    = sig_s1 * lo_s1;
        mixed_d = prod[2*DATA_W-2:DATA_W-1];
        // full-scale negative squared is the only product that wraps
        if (sig_s1 == S_MIN && lo_s1 == S_MIN) mixed_d = S_MAX;
    end

    always_comb begin
        sum        = acc_q + {{LOG2_DECIM{mixed_q[DATA_W-1]}}, mixed_q};
        acc_d      = sum;
        data_out_d = data_out_q;
        if (!rx_d2) begin
            acc_d = '0;
        end else if (win_last) begin
            acc_d      = '0;
            // upper bits of the sum == sum >>> LOG2_DECIM, floor rounding
            data_out_d = sum[ACC_W-1:LOG2_DECIM];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mixed_q    <= '0;
            acc_q      <= '0;
            data_out_q <= '0;
        end else begin
            mixed_q    <= mixed_d;
            acc_q      <= acc_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: rtl/signal_analysis.sv
// Quadrature receive demodulator: input register, shared window counter,
// and an I and a Q mixer/integrator lane.
module signal_analysis
  import signal_analysis_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LOG2_DECIM = LOG2_DECIM_DEF
) (
    input  logic             clk_8x,
    input  logic             rst,
    signal_analysis_if.slave bus
);

    logic signed [DATA_W-1:0]         sig_s1_d, sig_s1_q;
    logic [NUM_LANES-1:0][DATA_W-1:0] lo_s1_d, lo_s1_q, lane_out;
    logic [1:0]                       vld_pipe_d, vld_pipe_q;
    logic [LOG2_DECIM-1:0]            cnt_d, cnt_q;
    logic                             data_valid_d, data_valid_q;
    logic                             rx_d2, win_last;

    always_comb begin
        sig_s1_d        = bus.signal_in;
        lo_s1_d         = '0;
        lo_s1_d[LANE_I] = bus.dds_i;
        lo_s1_d[LANE_Q] = bus.dds_q;
        // rx travels with the samples: bit 0 = stage 1, bit 1 = stage 2
        vld_pipe_d      = {vld_pipe_q[0], bus.rx};
        rx_d2           = vld_pipe_q[1];
        win_last        = rx_d2 && (&cnt_q);
        cnt_d           = rx_d2 ? cnt_q + LOG2_DECIM'(1) : '0;
        data_valid_d    = win_last;
    end

    always_ff @(posedge clk_8x or posedge rst) begin
        if (rst) begin
            sig_s1_q     <= '0;
            lo_s1_q      <= '0;
            vld_pipe_q   <= '0;
            cnt_q        <= '0;
            data_valid_q <= 1'b0;
        end else begin
            sig_s1_q     <= sig_s1_d;
            lo_s1_q      <= lo_s1_d;
            vld_pipe_q   <= vld_pipe_d;
            cnt_q        <= cnt_d;
            data_valid_q <= data_valid_d;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        iq_mixer_integrator #(
            .DATA_W    (DATA_W),
            .LOG2_DECIM(LOG2_DECIM)
        ) u_lane (
            .clk     (clk_8x),
            .rst     (rst),
            .sig_s1  (sig_s1_q),
            .lo_s1   (lo_s1_q[l]),
            .rx_d2   (rx_d2),
            .win_last(win_last),
            .data_out(lane_out[l])
        );
    end

    assign bus.data_out_i = lane_out[LANE_I];
    assign bus.data_out_q = lane_out[LANE_Q];
    assign bus.data_valid = data_valid_q;

endmodule

// File: tb/tb_signal_analysis.sv
// Scoreboard bench for signal_analysis: the driver queues hand-computed
// window results, a negedge monitor pops and compares on each data_valid.
module tb_signal_analysis;
  import signal_analysis_pkg::*;

  typedef struct {
    int i;
    int q;
    int tol;
    int cyc;
  } exp_t;

  logic clk_8x = 1'b0;
  logic rst    = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // one period of a tone at fs/8, amplitude 16384, LO at full scale
  int tone_s [8] = '{16384, 11585, 0, -11585, -16384, -11585, 0, 11585};
  int tone_i [8] = '{32767, 23170, 0, -23170, -32767, -23170, 0, 23170};
  int tone_q [8] = '{0, 23170, 32767, 23170, 0, -23170, -32767, -23170};

  signal_analysis_if #(.DATA_W(DATA_W_DEF)) bus ();

  signal_analysis #(
    .DATA_W    (DATA_W_DEF),
    .LOG2_DECIM(LOG2_DECIM_DEF)
  ) dut (
    .clk_8x(clk_8x),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk_8x = ~clk_8x;
  always @(posedge clk_8x) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest queued window result.
  always @(negedge clk_8x) begin
    if (!rst && bus.data_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got data_valid with i=%0d q=%0d, expected none at cycle %0d",
                 bus.data_out_i, bus.data_out_q, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data_out_i", int'(bus.data_out_i), e.i, e.tol);
        chk("data_out_q", int'(bus.data_out_q), e.q, e.tol);
        chk("latency", cyc, e.cyc, 0);
      end
    end
  end

  task automatic drive(input int s, input int di, input int dq, input bit r);
    @(negedge clk_8x);
    bus.signal_in = sample_t'(s);
    bus.dds_i     = sample_t'(di);
    bus.dds_q     = sample_t'(dq);
    bus.rx        = r;
  endtask

  // Last sample driven now (cycle k) must strobe at cycle k+3.
  task automatic expect_out(input int ei, input int eq, input int tol);
    sb.push_back('{ei, eq, tol, cyc + 3});
  endtask

  task automatic window(input int s, input int di, input int dq, input int nwin,
                        input int ei, input int eq);
    for (int w = 0; w < nwin; w++)
      for (int k = 0; k < 8; k++) begin
        drive(s, di, dq, 1'b1);
        if (k == 7) expect_out(ei, eq, 0);
      end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 1'b0);
  endtask

  initial begin
    bus.signal_in = '0;
    bus.dds_i     = '0;
    bus.dds_q     = '0;
    bus.rx        = 1'b0;

    repeat (3) @(negedge clk_8x);
    chk("reset_out_i", int'(bus.data_out_i), 0, 0);
    chk("reset_out_q", int'(bus.data_out_q), 0, 0);
    chk("reset_valid", int'(bus.data_valid), 0, 0);
    @(negedge clk_8x);
    rst = 1'b0;

    // DC mix: 16384 * 32767 -> 16383 per sample, two back-to-back windows
    window(16384, 32767, 0, 2, 16383, 0);
    idle(5);

    // saturation on I, -32768 * 32767 -> -32767 on Q
    window(-32768, -32768, 32767, 1, 32767, -32767);
    idle(5);

    // mixed = -1 every sample; floor average stays -1
    window(-1, 32767, 0, 1, -1, 0);
    idle(5);

    // partial window is discarded; outputs must hold the previous result
    for (int k = 0; k < 5; k++) drive(32767, 32767, 32767, 1'b1);
    idle(6);
    chk("hold_out_i", int'(bus.data_out_i), -1, 0);
    chk("hold_out_q", int'(bus.data_out_q), 0, 0);
    chk("hold_valid", int'(bus.data_valid), 0, 0);
    // 8192*32767 -> 8191, 8192*-32768 -> -8192
    window(8192, 32767, -32768, 1, 8191, -8192);
    idle(5);

    // tone demodulation: I ~ A/2, Q ~ 0
    for (int w = 0; w < 3; w++)
      for (int k = 0; k < 8; k++) begin
        drive(tone_s[k], tone_i[k], tone_q[k], 1'b1);
        if (k == 7) expect_out(8192, 0, 2);
      end
    idle(5);

    // reset in the middle of a gated window
    for (int k = 0; k < 4; k++) drive(16384, 32767, 0, 1'b1);
    #2;
    rst    = 1'b1;
    bus.rx = 1'b0;
    #1;
    chk("midrst_out_i", int'(bus.data_out_i), 0, 0);
    chk("midrst_out_q", int'(bus.data_out_q), 0, 0);
    chk("midrst_valid", int'(bus.data_valid), 0, 0);
    @(negedge clk_8x);
    @(negedge clk_8x);
    rst = 1'b0;
    window(16384, 32767, 0, 1, 16383, 0);
    idle(5);

    for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk_8x);
    chk("scoreboard_drained", sb.size(), 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
